// File: rtl/servo_pwm_array.sv
// servo_pwm_array
//   Array of NCH hobby-servo PWM generators that share one frame counter.
//   Each channel keeps a target pulse width (changed by stepped commands)
//   and an active width that is latched only at frame start, so a command
//   never distorts the pulse that is already running.
//
// Ports
//   CLK       in   1      system clock, all state on rising edge
//   RST       in   1      synchronous active-high reset
//   STEP      in   1      one-cycle strobe that applies CMD
//   CMD       in   3*NCH  per-channel one-hot command: 100 left, 010 centre,
//                         001 right
//   PWM       out  NCH    registered servo pulse per channel
//   LEDS      out  3*NCH  command echo (legal codes only, else 000)
//   SYNC      out  1      registered one-cycle frame-start marker
//   AT_LIMIT  out  NCH    target sits at PMIN or PMAX
//
// Configuration macro
//   SERVO_HOLD_EN  defined: a stepped illegal command leaves the target as is.
//                  undefined: a stepped illegal command sets the target to 0,
//                  switching the channel off from the next frame.

module servo_pwm_array #(
  parameter int NCH    = 4,
  parameter int PERIOD = 2_000_000,
  parameter int PMIN   = 100_000,
  parameter int PCTR   = 150_000,
  parameter int PMAX   = 200_000,
  parameter int DELTA  = 500
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               STEP,
  input  logic [3*NCH-1:0]   CMD,
  output logic [NCH-1:0]     PWM,
  output logic [3*NCH-1:0]   LEDS,
  output logic               SYNC,
  output logic [NCH-1:0]     AT_LIMIT
);

  localparam int W = $clog2(PERIOD + 1);

  localparam logic [W-1:0] PMIN_W = W'(PMIN);
  localparam logic [W-1:0] PCTR_W = W'(PCTR);
  localparam logic [W-1:0] PMAX_W = W'(PMAX);
  localparam logic [W-1:0] LAST_W = W'(PERIOD - 1);

  if (!(PMIN > 0 && PMIN <= PCTR && PCTR <= PMAX && PMAX < PERIOD &&
        DELTA > 0 && NCH >= 1 && NCH <= 8)) begin : g_bad_params
    $error("servo_pwm_array: illegal parameter combination");
  end

  // Left step: signed W+1 difference so a small target saturates at PMIN
  // instead of wrapping to a huge width.
  function automatic logic [W-1:0] sat_left(input logic [W-1:0] t);
    logic signed [W:0] d;
    d = signed'({1'b0, t}) - signed'((W+1)'(DELTA));
    if (d > signed'((W+1)'(PMIN)))
      sat_left = W'(d);
    else
      sat_left = PMIN_W;
  endfunction

  // Right step: one extra bit of headroom keeps the sum from overflowing.
  function automatic logic [W-1:0] sat_right(input logic [W-1:0] t);
    logic [W:0] s;
    s = {1'b0, t} + (W+1)'(DELTA);
    if (s < (W+1)'(PMAX))
      sat_right = W'(s);
    else
      sat_right = PMAX_W;
  endfunction

  function automatic logic [W-1:0] next_tgt(input logic [W-1:0] t,
                                            input logic [2:0]   c);
    case (c)
      3'b010:  next_tgt = PCTR_W;
      3'b100:  next_tgt = sat_left(t);
      3'b001:  next_tgt = sat_right(t);
`ifdef SERVO_HOLD_EN
      default: next_tgt = t;
`else
      default: next_tgt = '0;
`endif
    endcase
  endfunction

  function automatic logic [2:0] echo(input logic [2:0] c);
    if (c == 3'b100 || c == 3'b010 || c == 3'b001)
      echo = c;
    else
      echo = 3'b000;
  endfunction

  logic [W-1:0]   cnt_p0;
  logic [W-1:0]   tgt [NCH];
  logic [W-1:0]   act [NCH];
  logic [NCH-1:0] pwm_p1;
  logic           sync_p1;

  // Stage p0 -> p1: frame counter, target/active widths, registered outputs.
  // At count 0 the comparison uses the target directly because the active
  // width is only being loaded on this same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_p0  <= '0;
      sync_p1 <= 1'b0;
      pwm_p1  <= '0;
      for (int i = 0; i < NCH; i++) begin
        tgt[i] <= PCTR_W;
        act[i] <= '0;
      end
    end else begin
      cnt_p0  <= (cnt_p0 == LAST_W) ? '0 : cnt_p0 + W'(1);
      sync_p1 <= (cnt_p0 == '0);
      for (int i = 0; i < NCH; i++) begin
        if (cnt_p0 == '0)
          act[i] <= tgt[i];
        pwm_p1[i] <= (cnt_p0 < ((cnt_p0 == '0) ? tgt[i] : act[i]));
        if (STEP)
          tgt[i] <= next_tgt(tgt[i], CMD[3*i +: 3]);
      end
    end
  end

  always_comb begin
    LEDS     = '0;
    AT_LIMIT = '0;
    for (int i = 0; i < NCH; i++) begin
      LEDS[3*i +: 3] = echo(CMD[3*i +: 3]);
      AT_LIMIT[i]    = (tgt[i] == PMIN_W) || (tgt[i] == PMAX_W);
    end
  end

  assign PWM  = pwm_p1;
  assign SYNC = sync_p1;

endmodule

// File: tb/tb_servo_pwm_array.sv
// tb_servo_pwm_array
//   Randomised plus directed stimulus for servo_pwm_array. A frame-level
//   reference model tracks each channel's target width and queues the width
//   each frame must carry; a monitor pops one entry per SYNC and checks the
//   PWM shape cycle by cycle, along with LEDS and AT_LIMIT.

module tb_servo_pwm_array;

  localparam int NCH    = 2;
  localparam int PERIOD = 100;
  localparam int PMIN   = 20;
  localparam int PCTR   = 30;
  localparam int PMAX   = 40;
  localparam int DELTA  = 4;

  typedef logic [NCH*16-1:0] wvec_t;

  logic             CLK  = 1'b0;
  logic             RST  = 1'b1;
  logic             STEP = 1'b0;
  logic [3*NCH-1:0] CMD  = '0;
  logic [NCH-1:0]   PWM;
  logic [3*NCH-1:0] LEDS;
  logic             SYNC;
  logic [NCH-1:0]   AT_LIMIT;

  servo_pwm_array #(
    .NCH(NCH), .PERIOD(PERIOD), .PMIN(PMIN), .PCTR(PCTR),
    .PMAX(PMAX), .DELTA(DELTA)
  ) dut (
    .CLK(CLK), .RST(RST), .STEP(STEP), .CMD(CMD),
    .PWM(PWM), .LEDS(LEDS), .SYNC(SYNC), .AT_LIMIT(AT_LIMIT)
  );

  always #5 CLK = ~CLK;

  int    n_checks = 0;
  int    n_fail   = 0;
  wvec_t expq[$];
  int    tgt_m [NCH];
  int    mcnt     = 0;
  bit    started  = 1'b0;
  bit    rst_seen = 1'b0;
  wvec_t push_v;
  wvec_t cur      = '0;
  int    k        = 0;
  bit    active   = 1'b0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference rules for one stepped command, in plain integer arithmetic.
  function automatic int model_step(input int t, input logic [2:0] c);
    case (c)
      3'b010:  return PCTR;
      3'b100:  return (t - DELTA > PMIN) ? t - DELTA : PMIN;
      3'b001:  return (t + DELTA < PMAX) ? t + DELTA : PMAX;
`ifdef SERVO_HOLD_EN
      default: return t;
`else
      default: return 0;
`endif
    endcase
  endfunction

  // Reference model: every frame start queues the widths of that frame.
  always @(posedge CLK) begin
    if (RST) begin
      mcnt     = 0;
      started  = 1'b1;
      rst_seen = 1'b1;
      for (int c = 0; c < NCH; c++) tgt_m[c] = PCTR;
    end else if (started) begin
      rst_seen = 1'b0;
      if (mcnt == 0) begin
        for (int c = 0; c < NCH; c++) push_v[c*16 +: 16] = 16'(tgt_m[c]);
        expq.push_back(push_v);
      end
      if (STEP)
        for (int c = 0; c < NCH; c++) tgt_m[c] = model_step(tgt_m[c], CMD[3*c +: 3]);
      mcnt = (mcnt + 1) % PERIOD;
    end
  end

  // Monitor: samples on the falling edge.
  always @(negedge CLK) begin
    if (started) begin
      if (rst_seen) begin
        for (int c = 0; c < NCH; c++) check("pwm_in_reset", PWM[c], 0);
        check("sync_in_reset", SYNC, 0);
        active = 1'b0;
      end else begin
        if (SYNC) begin
          if (active) check("frame_len", k, PERIOD - 1);
          check("queue_depth_at_sync", expq.size(), 1);
          if (expq.size() > 0) cur = expq.pop_front();
          k      = 0;
          active = 1'b1;
        end else if (active) begin
          k++;
          if (k >= PERIOD) begin
            check("sync_missing", k, PERIOD - 1);
            active = 1'b0;
          end
        end
        for (int c = 0; c < NCH; c++)
          check($sformatf("pwm%0d", c), PWM[c],
                (active && (k < int'(cur[c*16 +: 16]))) ? 1 : 0);
      end
      for (int c = 0; c < NCH; c++) begin
        logic [2:0] s;
        s = CMD[3*c +: 3];
        check($sformatf("leds%0d", c), LEDS[3*c +: 3],
              (s == 3'b100 || s == 3'b010 || s == 3'b001) ? s : 3'b000);
        check($sformatf("at_limit%0d", c), AT_LIMIT[c],
              (tgt_m[c] == PMIN || tgt_m[c] == PMAX) ? 1 : 0);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_cnt(input int c);
    int g = 0;
    while (mcnt != c && g < PERIOD + 2) begin
      tick();
      g++;
    end
    check("wait_cnt_reached", mcnt, c);
  endtask

  task automatic step_at(input int c, input logic [3*NCH-1:0] cmd);
    wait_cnt(c);
    STEP = 1'b1;
    CMD  = cmd;
    tick();
    STEP = 1'b0;
  endtask

  initial begin
    // Reset and idle frames at centre width.
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    repeat (2*PERIOD + 5) tick();

    // Three right steps on ch0, ch1 held at centre: 34, 38, 40.
    repeat (3) step_at(50, {3'b010, 3'b001});
    repeat (PERIOD + 10) tick();

    // Back to centre, then left steps down to the PMIN floor: 26, 22, 20.
    step_at(50, {3'b010, 3'b010});
    repeat (3) step_at(50, {3'b010, 3'b100});
    repeat (PERIOD + 10) tick();

    // Illegal command on ch0.
    step_at(50, {3'b010, 3'b011});
    repeat (2*PERIOD) tick();
    step_at(50, {3'b010, 3'b010});

    // Widen ch0 to 38, then reset during its pulse at count 10.
    repeat (2) step_at(50, {3'b010, 3'b001});
    wait_cnt(10);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    repeat (2*PERIOD + 5) tick();

    // Centre command exactly at count 0 from width 40.
    repeat (3) step_at(50, {3'b010, 3'b001});
    step_at(0, {3'b010, 3'b010});
    repeat (2*PERIOD + 5) tick();

    // Random commands, steps and occasional resets.
    repeat (3000) begin
      for (int c = 0; c < NCH; c++) begin
        int r;
        r = $urandom_range(0, 4);
        CMD[3*c +: 3] = (r == 0) ? 3'b100 : (r == 1) ? 3'b010 :
                        (r == 2) ? 3'b001 : 3'($urandom);
      end
      STEP = ($urandom_range(0, 7) == 0);
      RST  = ($urandom_range(0, 499) == 0);
      tick();
    end
    RST  = 1'b0;
    STEP = 1'b0;
    repeat (2*PERIOD + 5) tick();

    check("leftover_frames", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
